// File: rtl/pc_fetch.sv
// IF-stage PC register and I-cache request FSM; a redirect during a miss is parked until it ends.
// Define PREFETCH_BUF_EN to add a one-entry buffer that captures a word completing under Stall.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    input  logic        ICACHE_stall,
    input  logic [31:0] ICACHE_rdata,
    output logic [31:0] IR_IF,
    output logic [31:0] PC_IF,
    output logic        Fetch_busy
);

    typedef enum logic {StFetch, StDrop} state_e;

    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend;
    logic [31:0] w_pc_inc;
    logic [31:0] w_redir_pc;
    logic        w_buf_full;
    logic        w_hit;
    logic        w_have;

`ifdef PREFETCH_BUF_EN
    logic        r_buf_full;
    logic [31:0] r_buf_ir;
    logic [31:0] r_buf_pc;
    assign w_buf_full = r_buf_full;
`else
    assign w_buf_full = 1'b0;
`endif

    assign w_pc_inc   = r_pc + 32'd4;
    assign w_redir_pc = Redirect_PC & 32'hFFFF_FFFC;

    always_comb begin
        ICACHE_ren  = rst_n && !w_buf_full;
        ICACHE_addr = r_pc[31:2];
        w_hit       = ICACHE_ren && (r_state == StFetch) && !ICACHE_stall;
        w_have      = rst_n && (w_hit || w_buf_full);
        Fetch_busy  = !w_have;
        IR_IF       = '0;
        PC_IF       = '0;
        // A redirect squashes whatever word is on offer this cycle.
        if (w_have && !Redirect) begin
`ifdef PREFETCH_BUF_EN
            if (w_buf_full) begin
                IR_IF = r_buf_ir;
                PC_IF = r_buf_pc;
            end else
`endif
            begin
                IR_IF = ICACHE_rdata;
                PC_IF = w_pc_inc;
            end
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
            r_pc    <= RESET_PC & 32'hFFFF_FFFC;
            r_pend  <= '0;
`ifdef PREFETCH_BUF_EN
            r_buf_full <= 1'b0;
            r_buf_ir   <= '0;
            r_buf_pc   <= '0;
`endif
        end else begin
            unique case (r_state)
                StFetch: begin
                    if (Redirect) begin
                        // Never change the cache address mid-miss; park the target instead.
                        if (ICACHE_ren && ICACHE_stall) begin
                            r_pend  <= w_redir_pc;
                            r_state <= StDrop;
                        end else begin
                            r_pc <= w_redir_pc;
                        end
`ifdef PREFETCH_BUF_EN
                        r_buf_full <= 1'b0;
`endif
                    end else if (w_hit && !Stall) begin
                        r_pc <= w_pc_inc;
`ifdef PREFETCH_BUF_EN
                    end else if (w_hit) begin
                        r_buf_full <= 1'b1;
                        r_buf_ir   <= ICACHE_rdata;
                        r_buf_pc   <= w_pc_inc;
                        r_pc       <= w_pc_inc;
                    end else if (w_buf_full && !Stall) begin
                        r_buf_full <= 1'b0;
`endif
                    end
                end
                StDrop: begin
                    if (!ICACHE_stall) begin
                        r_pc    <= Redirect ? w_redir_pc : r_pend;
                        r_state <= StFetch;
                    end else if (Redirect) begin
                        r_pend <= w_redir_pc;
                    end
                end
                default: r_state <= StFetch;
            endcase
        end
    end

endmodule
